// File: rtl/aes_block_packer_if.sv
// Stream bundle for the AES block packer: byte-beat input side, 128-bit block output side,
// plus FIFO occupancy and the sticky protocol-error flag.
interface aes_block_packer_if #(
   parameter int IN_BYTES = 1
);
   logic [8*IN_BYTES-1:0] s_axis_tdata;
   logic [IN_BYTES-1:0]   s_axis_tkeep;
   logic                  s_axis_tvalid;
   logic                  s_axis_tlast;
   logic                  s_axis_tready;
   logic [127:0]          m_axis_tdata;
   logic [4:0]            m_axis_tbytes;
   logic                  m_axis_tlast;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic [3:0]            level;
   logic                  err;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tbytes, m_axis_tlast, m_axis_tvalid,
             level, err
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tbytes, m_axis_tlast, m_axis_tvalid,
             level, err
   );
endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit AES blocks (zero or PKCS#7 padding) and buffers them
// in a small first-word-fall-through block FIFO.
module aes_block_packer #(
   parameter int IN_BYTES = 1,
   parameter int NUM_BUF  = 2,
   parameter int PAD_MODE = 0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   aes_block_packer_if.slave bus
);
   if (!(IN_BYTES == 1 || IN_BYTES == 2 || IN_BYTES == 4 || IN_BYTES == 8 || IN_BYTES == 16) ||
       !(NUM_BUF == 2 || NUM_BUF == 4 || NUM_BUF == 8) ||
       !(PAD_MODE == 0 || PAD_MODE == 1)) begin : g_bad_param
      $error("aes_block_packer: illegal parameter value");
   end

   localparam int PW = $clog2(NUM_BUF);
   localparam int EW = 128 + 5 + 1;
   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_PAD  = 1'b1;
   localparam logic [IN_BYTES-1:0] KEEP_ALL = '1;

   logic [0:0]    state_reg, state_next;
   logic [127:0]  asm_reg, asm_next;
   logic [4:0]    count_reg, count_next;
   logic          err_reg, err_next;
   logic          run_reg;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [3:0]    level_reg;
   logic [EW-1:0] mem [NUM_BUF];

   logic          not_full, accept, pop, push;
   logic          keep_contig, beat_ok;
   logic [4:0]    beat_bytes, total;
   logic [7:0]    pad_byte;
   logic [127:0]  merged, padded;
   logic [EW-1:0] push_entry, head;

   // run_reg holds tready low until the first edge after reset is released
   assign not_full          = level_reg < 4'(NUM_BUF);
   assign bus.s_axis_tready = run_reg && (state_reg == ST_FILL) && not_full;
   assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
   assign pop               = bus.m_axis_tvalid && bus.m_axis_tready;

   assign keep_contig = ((bus.s_axis_tkeep & (bus.s_axis_tkeep + IN_BYTES'(1))) == '0) &&
                        (bus.s_axis_tkeep != '0);
   assign beat_ok     = keep_contig && (bus.s_axis_tlast || bus.s_axis_tkeep == KEEP_ALL);
   assign total       = count_reg + beat_bytes;
   assign pad_byte    = (PAD_MODE == 1) ? {3'b000, 5'd16 - total} : 8'h00;

   always_comb begin
      beat_bytes = '0;
      merged     = asm_reg;
      for (int i = 0; i < IN_BYTES; i++) begin
         beat_bytes = beat_bytes + 5'(bus.s_axis_tkeep[i]);
         // count is always a whole number of beats, so lanes land contiguously after it
         if (bus.s_axis_tkeep[i] && (int'(count_reg) + i) < 16)
            merged[8*(15 - int'(count_reg) - i) +: 8] = bus.s_axis_tdata[8*i +: 8];
      end
   end

   always_comb begin
      padded = '0;
      for (int j = 0; j < 16; j++)
         padded[8*(15 - j) +: 8] = (j < int'(total)) ? merged[8*(15 - j) +: 8] : pad_byte;
   end

   always_comb begin
      state_next = state_reg;
      asm_next   = asm_reg;
      count_next = count_reg;
      err_next   = err_reg;
      push       = 1'b0;
      push_entry = {padded, total, bus.s_axis_tlast};
      if (state_reg == ST_FILL) begin
         if (accept) begin
            if (!beat_ok) begin
               err_next = 1'b1;
            end else if (total == 5'd16 || bus.s_axis_tlast) begin
               push       = 1'b1;
               asm_next   = '0;
               count_next = '0;
               // an exact-block PKCS#7 message still owes a full pad block
               if (total == 5'd16 && bus.s_axis_tlast && PAD_MODE == 1) begin
                  push_entry = {padded, 5'd16, 1'b0};
                  state_next = ST_PAD;
               end
            end else begin
               asm_next   = merged;
               count_next = total;
            end
         end
      end else begin
         if (not_full) begin
            push       = 1'b1;
            push_entry = {{16{8'h10}}, 5'd0, 1'b1};
            state_next = ST_FILL;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg  <= ST_FILL;
         asm_reg    <= '0;
         count_reg  <= '0;
         err_reg    <= 1'b0;
         run_reg    <= 1'b0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         state_reg <= state_next;
         asm_reg   <= asm_next;
         count_reg <= count_next;
         err_reg   <= err_next;
         run_reg   <= 1'b1;
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 4'd1;
            2'b01:   level_reg <= level_reg - 4'd1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_reg] <= push_entry;
   end

   // stale RAM contents are masked so an empty FIFO presents all-zero outputs
   assign head              = mem[rd_ptr_reg];
   assign bus.m_axis_tvalid = (level_reg != 4'd0);
   assign bus.m_axis_tdata  = bus.m_axis_tvalid ? head[EW-1 -: 128] : '0;
   assign bus.m_axis_tbytes = bus.m_axis_tvalid ? head[5:1] : '0;
   assign bus.m_axis_tlast  = bus.m_axis_tvalid ? head[0] : 1'b0;
   assign bus.level         = level_reg;
   assign bus.err           = err_reg;
endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: a 4-byte PKCS#7 instance and a 1-byte zero-pad instance,
// checked against a message-level padding model.
`timescale 1ns/1ps
module tb_aes_block_packer;
   typedef logic [133:0] blk_t;
   typedef logic [7:0]   bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_block_packer_if #(.IN_BYTES(4)) ifa();
   aes_block_packer_if #(.IN_BYTES(1)) ifb();

   aes_block_packer #(.IN_BYTES(4), .NUM_BUF(2), .PAD_MODE(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .bus(ifa));
   aes_block_packer #(.IN_BYTES(1), .NUM_BUF(4), .PAD_MODE(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .bus(ifb));

   int   checks = 0;
   int   errors = 0;
   blk_t got_a[$], got_b[$], exp_a[$], exp_b[$];
   int   mode_a = 1, mode_b = 1;
   logic rnd_a = 1'b1, rnd_b = 1'b1;

   assign ifa.m_axis_tready = (mode_a == 2) ? rnd_a : (mode_a == 1);
   assign ifb.m_axis_tready = (mode_b == 2) ? rnd_b : (mode_b == 1);

   always @(negedge clk) begin
      rnd_a = ($urandom_range(0, 3) != 0);
      rnd_b = ($urandom_range(0, 3) != 0);
   end

   always @(posedge clk) begin
      if (!rst && ifa.m_axis_tvalid && ifa.m_axis_tready)
         got_a.push_back({ifa.m_axis_tdata, ifa.m_axis_tbytes, ifa.m_axis_tlast});
      if (!rst && ifb.m_axis_tvalid && ifb.m_axis_tready)
         got_b.push_back({ifb.m_axis_tdata, ifb.m_axis_tbytes, ifb.m_axis_tlast});
   end

   // Message-level reference: split into 16-byte blocks, pad the tail, PKCS#7 adds a full pad block
   task automatic model_msg(input bq_t m, input bit pkcs, input bit to_a);
      int n = m.size();
      int nblk = (n + 15) / 16;
      int cnt;
      logic [127:0] d;
      bit lastf;
      for (int b = 0; b < nblk; b++) begin
         cnt = (n - 16*b > 16) ? 16 : n - 16*b;
         d = '0;
         for (int j = 0; j < 16; j++)
            d[127 - 8*j -: 8] = (j < cnt) ? m[16*b + j] : (pkcs ? 8'(16 - cnt) : 8'h00);
         lastf = (b == nblk - 1) && !(pkcs && cnt == 16);
         if (to_a) exp_a.push_back({d, 5'(cnt), lastf});
         else      exp_b.push_back({d, 5'(cnt), lastf});
      end
      if (pkcs && (n % 16) == 0) begin
         if (to_a) exp_a.push_back({{16{8'h10}}, 5'd0, 1'b1});
         else      exp_b.push_back({{16{8'h10}}, 5'd0, 1'b1});
      end
   endtask

   task automatic make_msg(input int n, output bq_t m);
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
   endtask

   // Beat drivers start and end at a falling edge; tready is register-derived so it is sampled there
   task automatic send_beat_a(input logic [31:0] d, input logic [3:0] k, input bit last);
      int n = 0;
      ifa.s_axis_tdata = d; ifa.s_axis_tkeep = k; ifa.s_axis_tlast = last; ifa.s_axis_tvalid = 1'b1;
      while (!ifa.s_axis_tready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL send_a_timeout: tready=%0b required 1", ifa.s_axis_tready);
      end
      @(negedge clk);
      ifa.s_axis_tvalid = 1'b0;
   endtask

   task automatic send_beat_b(input logic [7:0] d, input bit last);
      int n = 0;
      ifb.s_axis_tdata = d; ifb.s_axis_tkeep = 1'b1; ifb.s_axis_tlast = last; ifb.s_axis_tvalid = 1'b1;
      while (!ifb.s_axis_tready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL send_b_timeout: tready=%0b required 1", ifb.s_axis_tready);
      end
      @(negedge clk);
      ifb.s_axis_tvalid = 1'b0;
   endtask

   task automatic send_msg_a(input bq_t m);
      logic [31:0] d;
      logic [3:0]  k;
      for (int i = 0; i < m.size(); i += 4) begin
         d = '0; k = '0;
         for (int j = 0; j < 4; j++)
            if (i + j < m.size()) begin d[8*j +: 8] = m[i + j]; k[j] = 1'b1; end
         send_beat_a(d, k, (i + 4 >= m.size()));
      end
   endtask

   task automatic send_msg_b(input bq_t m);
      for (int i = 0; i < m.size(); i++) send_beat_b(m[i], (i == m.size() - 1));
   endtask

   task automatic drain(input bit to_a, output bit ok);
      int n = 0;
      if (to_a) while (got_a.size() < exp_a.size() && n < 3000) begin @(negedge clk); n++; end
      else      while (got_b.size() < exp_b.size() && n < 3000) begin @(negedge clk); n++; end
      ok = (n < 3000);
      repeat (8) @(negedge clk);
   endtask

   task automatic clear_q();
      got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({ifa.s_axis_tready, ifa.m_axis_tvalid, ifa.level, ifa.err, ifa.m_axis_tbytes, ifa.m_axis_tlast} !== '0) begin
         errors++;
         $display("FAIL rst_ctrl_a: got tready=%b valid=%b level=%0d err=%b tbytes=%0d tlast=%b required all 0",
                  ifa.s_axis_tready, ifa.m_axis_tvalid, ifa.level, ifa.err, ifa.m_axis_tbytes, ifa.m_axis_tlast);
      end
      checks++;
      if (ifa.m_axis_tdata !== '0 || ifb.m_axis_tdata !== '0) begin
         errors++;
         $display("FAIL rst_tdata: got %h / %h required 0", ifa.m_axis_tdata, ifb.m_axis_tdata);
      end
      checks++;
      if (ifb.s_axis_tready !== 1'b0 || ifb.level !== 4'd0) begin
         errors++;
         $display("FAIL rst_ctrl_b: got tready=%b level=%0d required 0/0", ifb.s_axis_tready, ifb.level);
      end
      rst = 1'b0;
      checks++;
      if (ifa.s_axis_tready !== 1'b0) begin
         errors++; $display("FAIL rst_release_early: tready=%b required 0", ifa.s_axis_tready);
      end
      @(negedge clk);
      checks++;
      if (ifa.s_axis_tready !== 1'b1 || ifb.s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL rst_release_edge: tready a=%b b=%b required 1/1", ifa.s_axis_tready, ifb.s_axis_tready);
      end
   endtask

   task automatic test_zero_pad();
      bq_t m;
      bit ok;
      clear_q();
      for (int i = 0; i < 16; i++) m.push_back(8'(i));
      send_msg_b(m);
      checks++;
      if (ifb.m_axis_tvalid !== 1'b1 || ifb.m_axis_tdata !== 128'h000102030405060708090A0B0C0D0E0F ||
          ifb.m_axis_tbytes !== 5'd16 || ifb.m_axis_tlast !== 1'b1) begin
         errors++;
         $display("FAIL zero_pad_block: got v=%b %h bytes=%0d last=%b required v=1 000102..0F bytes=16 last=1",
                  ifb.m_axis_tvalid, ifb.m_axis_tdata, ifb.m_axis_tbytes, ifb.m_axis_tlast);
      end
      drain(1'b0, ok);
      checks++;
      if (got_b.size() != 1) begin
         errors++; $display("FAIL zero_pad_count: got %0d blocks required 1", got_b.size());
      end
   endtask

   task automatic test_pkcs7_partial();
      bit ok;
      clear_q();
      send_beat_a(32'h14131211, 4'hF, 1'b0);
      send_beat_a(32'h00000015, 4'h1, 1'b1);
      checks++;
      if (ifa.m_axis_tvalid !== 1'b1 || ifa.m_axis_tdata !== 128'h11121314150B0B0B0B0B0B0B0B0B0B0B ||
          ifa.m_axis_tbytes !== 5'd5 || ifa.m_axis_tlast !== 1'b1) begin
         errors++;
         $display("FAIL pkcs7_partial: got v=%b %h bytes=%0d last=%b required v=1 1112131415 0B.. bytes=5 last=1",
                  ifa.m_axis_tvalid, ifa.m_axis_tdata, ifa.m_axis_tbytes, ifa.m_axis_tlast);
      end
      drain(1'b1, ok);
   endtask

   task automatic test_exact_pad();
      bq_t m;
      bit ok;
      clear_q();
      make_msg(16, m);
      model_msg(m, 1'b1, 1'b1);
      send_msg_a(m);
      checks++;
      if (ifa.s_axis_tready !== 1'b0) begin
         errors++; $display("FAIL exact_pad_tready_low: got %b required 0", ifa.s_axis_tready);
      end
      @(negedge clk);
      checks++;
      if (ifa.s_axis_tready !== 1'b1) begin
         errors++; $display("FAIL exact_pad_tready_back: got %b required 1", ifa.s_axis_tready);
      end
      drain(1'b1, ok);
      checks++;
      if (!ok || got_a.size() != exp_a.size()) begin
         errors++; $display("FAIL exact_pad_count: got %0d blocks required %0d", got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL exact_pad_blk%0d: got %h required %h", i, got_a[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      bq_t m1, m2, m3;
      bit ok;
      clear_q();
      mode_a = 0;
      make_msg(8, m1); make_msg(8, m2); make_msg(8, m3);
      model_msg(m1, 1'b1, 1'b1); model_msg(m2, 1'b1, 1'b1); model_msg(m3, 1'b1, 1'b1);
      send_msg_a(m1);
      send_msg_a(m2);
      checks++;
      if (ifa.level !== 4'd2 || ifa.s_axis_tready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: got level=%0d tready=%b required 2/0", ifa.level, ifa.s_axis_tready);
      end
      checks++;
      if ({ifa.m_axis_tdata, ifa.m_axis_tbytes, ifa.m_axis_tlast} !== exp_a[0]) begin
         errors++; $display("FAIL bp_head: got %h required %h",
                            {ifa.m_axis_tdata, ifa.m_axis_tbytes, ifa.m_axis_tlast}, exp_a[0]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({ifa.m_axis_tdata, ifa.m_axis_tbytes, ifa.m_axis_tlast} !== exp_a[0] || ifa.m_axis_tvalid !== 1'b1) begin
         errors++; $display("FAIL bp_hold: got v=%b %h required v=1 %h", ifa.m_axis_tvalid,
                            {ifa.m_axis_tdata, ifa.m_axis_tbytes, ifa.m_axis_tlast}, exp_a[0]);
      end
      mode_a = 1;
      send_msg_a(m3);
      drain(1'b1, ok);
      checks++;
      if (!ok || got_a.size() != exp_a.size()) begin
         errors++; $display("FAIL bp_count: got %0d blocks required %0d", got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL bp_blk%0d: got %h required %h", i, got_a[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_bad_keep();
      bq_t m;
      bit ok;
      clear_q();
      send_beat_a(32'hAABBCCDD, 4'h5, 1'b1);
      send_beat_a(32'h11223344, 4'h0, 1'b1);
      send_beat_a(32'h55667788, 4'h3, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (ifa.err !== 1'b1 || ifa.level !== 4'd0 || got_a.size() != 0) begin
         errors++;
         $display("FAIL bad_keep_drop: got err=%b level=%0d popped=%0d required 1/0/0",
                  ifa.err, ifa.level, got_a.size());
      end
      make_msg(6, m);
      model_msg(m, 1'b1, 1'b1);
      send_msg_a(m);
      drain(1'b1, ok);
      checks++;
      if (!ok || got_a.size() != 1 || got_a[0] !== exp_a[0]) begin
         errors++; $display("FAIL bad_keep_recover: got %0d blocks first=%h required 1 block %h",
                            got_a.size(), (got_a.size() > 0) ? got_a[0] : '0, exp_a[0]);
      end
      checks++;
      if (ifa.err !== 1'b1) begin
         errors++; $display("FAIL bad_keep_sticky: err=%b required 1", ifa.err);
      end
   endtask

   task automatic test_reset_mid();
      bq_t m;
      bit ok;
      clear_q();
      mode_a = 0;
      make_msg(8, m);
      send_msg_a(m);
      for (int i = 0; i < 7; i++) send_beat_b(8'hE0 + 8'(i), 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if (ifa.m_axis_tvalid !== 1'b0 || ifa.level !== 4'd0 || ifa.err !== 1'b0 || ifa.m_axis_tdata !== '0 ||
          ifb.s_axis_tready !== 1'b0 || ifb.level !== 4'd0) begin
         errors++;
         $display("FAIL mid_rst_clear: got a v=%b lvl=%0d err=%b b tready=%b lvl=%0d required all 0",
                  ifa.m_axis_tvalid, ifa.level, ifa.err, ifb.s_axis_tready, ifb.level);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      mode_a = 1;
      make_msg(16, m);
      model_msg(m, 1'b0, 1'b0);
      send_msg_b(m);
      drain(1'b0, ok);
      drain(1'b1, ok);
      checks++;
      if (got_b.size() != 1 || got_b[0] !== exp_b[0]) begin
         errors++; $display("FAIL mid_rst_new: got %0d blocks first=%h required 1 block %h",
                            got_b.size(), (got_b.size() > 0) ? got_b[0] : '0, exp_b[0]);
      end
      checks++;
      if (got_a.size() != 0) begin
         errors++; $display("FAIL mid_rst_residual: got %0d blocks required 0", got_a.size());
      end
   endtask

   task automatic test_random();
      bq_t m;
      bit ok;
      clear_q();
      mode_a = 2; mode_b = 2;
      for (int t = 0; t < 12; t++) begin
         make_msg($urandom_range(1, 40), m);
         model_msg(m, 1'b1, 1'b1);
         send_msg_a(m);
         make_msg($urandom_range(1, 40), m);
         model_msg(m, 1'b0, 1'b0);
         send_msg_b(m);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(1'b1, ok);
      checks++;
      if (!ok || got_a.size() != exp_a.size()) begin
         errors++; $display("FAIL rand_count_a: got %0d blocks required %0d", got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i]) begin
            errors++; $display("FAIL rand_a_blk%0d: got %h required %h", i, got_a[i], exp_a[i]);
         end
      end
      drain(1'b0, ok);
      checks++;
      if (!ok || got_b.size() != exp_b.size()) begin
         errors++; $display("FAIL rand_count_b: got %0d blocks required %0d", got_b.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
         checks++;
         if (got_b[i] !== exp_b[i]) begin
            errors++; $display("FAIL rand_b_blk%0d: got %h required %h", i, got_b[i], exp_b[i]);
         end
      end
      mode_a = 1; mode_b = 1;
   endtask

   initial begin
      ifa.s_axis_tdata = '0; ifa.s_axis_tkeep = '0; ifa.s_axis_tvalid = 1'b0; ifa.s_axis_tlast = 1'b0;
      ifb.s_axis_tdata = '0; ifb.s_axis_tkeep = '0; ifb.s_axis_tvalid = 1'b0; ifb.s_axis_tlast = 1'b0;
      test_reset();
      test_zero_pad();
      test_pkcs7_partial();
      test_exact_pad();
      test_backpressure();
      test_bad_keep();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 Parameter IN_BYTES, default 1: input beat width in bytes; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter NUM_BUF, default 2: depth of the block FIFO in 128-bit entries; power of two, 2..8.
REQ-003 Parameter PAD_MODE, default 0: 0 = zero padding, 1 = PKCS#7 padding.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 s_axis_tdata_i  in  8*IN_BYTES  input bytes; lane 0 (bits [7:0]) is the earliest byte.
REQ-007 s_axis_tkeep_i  in  IN_BYTES  byte enables; all-ones except on a tlast beat.
REQ-008 s_axis_tvalid_i  in  1  input beat valid.
REQ-009 s_axis_tlast_i  in  1  last beat of a message.
REQ-010 s_axis_tready_o  out  1  input ready.
REQ-011 m_axis_tdata_o  out  128  assembled block; the earliest byte is at [127:120].
REQ-012 m_axis_tbytes_o  out  5  count of message bytes in the block, 0..16, excluding padding.
REQ-013 m_axis_tlast_o  out  1  final block of a message.
REQ-014 m_axis_tvalid_o  out  1  output block valid.
REQ-015 m_axis_tready_i  in  1  output ready.
REQ-016 level_o  out  4  number of FIFO entries occupied.
REQ-017 err_o  out  1  sticky protocol-error flag.

Function
REQ-018 A beat is accepted when s_axis_tvalid_i and s_axis_tready_o are both high; a block is popped when m_axis_tvalid_o and m_axis_tready_i are both high.
REQ-019 Accepted bytes are shifted into a 128-bit assembly register in arrival order; the byte count occupies 0..16.
REQ-020 A block is pushed to the FIFO on the accepting edge when the count reaches 16, with tbytes=16 and tlast=s_axis_tlast_i; the count then returns to 0.
REQ-021 When a tlast beat leaves the count between 1 and 15, the remaining bytes are padded and the block is pushed on the same edge with tlast=1:
- PAD_MODE=0 fills with 0x00.
- PAD_MODE=1 fills each pad byte with 16-count.
REQ-022 PAD_MODE=1, tlast filling an exact block: the data block is pushed with tlast=0, and the FSM enters PAD.
REQ-023 In PAD, s_axis_tready_o=0; a block of sixteen 0x10 bytes (tbytes=0, tlast=1) is pushed once the FIFO is not full; the FSM then returns to FILL.
REQ-024 FSM states and transitions: FILL->PAD per REQ-022; PAD->FILL on the pad push; no other transitions.
REQ-025 s_axis_tready_o = (state==FILL) && (level_o<NUM_BUF); it is registered-state-derived only, with no combinational path from m_axis_tready_i.
REQ-026 The FIFO is first-word fall-through: m_axis_tvalid_o=(level_o!=0), with data, tbytes and tlast taken from the head entry.
REQ-027 Push-to-valid latency is one cycle: a push on edge N asserts m_axis_tvalid_o after edge N if the FIFO was empty.
REQ-028 A simultaneous push and pop leaves level_o unchanged; a pop when empty or a push when full cannot occur.
REQ-029 Read and write pointers wrap modulo NUM_BUF.
REQ-030 An accepted beat with non-contiguous tkeep (not of the form 0..01..1), or with tkeep!=all-ones while tlast=0, sets err_o and is dropped entirely.
REQ-031 An accepted beat with tkeep=0 likewise sets err_o and is dropped, including its tlast.
REQ-032 The output holds while m_axis_tvalid_o=1 and m_axis_tready_i=0: tdata, tbytes and tlast remain stable.
REQ-033 IN_BYTES divides 16, so beats never straddle blocks; illegal parameter values are rejected at elaboration.

Reset
REQ-034 When rst_i is asserted, the following are cleared immediately: assembly register=0, count=0, state=FILL, pointers=0, level_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tbytes_o=0, m_axis_tlast_o=0, err_o=0, s_axis_tready_o=0.
REQ-035 s_axis_tready_o rises on the first clock edge after rst_i deasserts.
REQ-036 Reset mid-message discards the partial block and all FIFO contents; no residual block is emitted.

Verification
REQ-037 IN_BYTES=1, PAD_MODE=0: send bytes 0x00..0x0F with tlast on 0x0F, m_ready=1 -> one block 0x000102..0F, tbytes=16, tlast=1, valid one cycle after the last accept.
REQ-038 IN_BYTES=4, PAD_MODE=1: send 5 bytes 0x11..0x15 (tkeep=0x1 on tlast beat) -> block 0x1112131415 followed by eleven 0x0B bytes, tbytes=5, tlast=1.
REQ-039 IN_BYTES=16, PAD_MODE=1: single full beat with tlast -> data block (tbytes=16, tlast=0), then 0x1010..10 (tbytes=0, tlast=1); s_tready is low for exactly one cycle while the FIFO is not full.
REQ-040 NUM_BUF=2, m_ready=0: push 3 blocks -> s_tready drops after the 2nd block and level_o=2; after releasing m_ready, blocks emerge in order with no loss.
REQ-041 Non-contiguous tkeep=0x5 on a tlast beat (IN_BYTES=4) -> err_o=1 persists, no block pushed, and a following good message is packed correctly.
REQ-042 Assert rst_i after 7 bytes of a message -> all outputs are at reset values; a new 16-byte message emits exactly one block, with none of the old bytes present.
